matrix_mac_core: RTL and testbench
==================================

MATRIX_MAC_CORE -- requirements
Module: matrix_mac_core

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W  8  signed element width
  MAX_DIM  4  largest row/column count per matrix
  ACC_W  2*DATA_W+$clog2(MAX_DIM)  signed result width (18 at defaults)
  DIM_W  $clog2(MAX_DIM+1)  dimension field width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  rst  in  1  reset, asynchronous, active-low
  start  in  1  begin job, sampled in IDLE only
  a_rows, a_cols, b_rows, b_cols  in  DIM_W each  job dimensions, sampled with start
  in_valid  in  1  element offered
  in_ready  out  1  element accepted when in_valid&&in_ready
  in_data  in  DATA_W  signed element, A then B, row-major
  out_valid  out  1  result element offered
  out_ready  in  1  sink accepts result
  out_data  out  ACC_W  signed C[r][c]
  out_row_end  out  1  qualifies out_data as last column of a row
  out_last  out  1  qualifies out_data as final element C[a_rows-1][b_cols-1]
  illegal  out  1  one-cycle pulse: job rejected
  busy  out  1  high in any state except IDLE
  done  out  1  one-cycle pulse: job complete

Function
REQ-003 FSM states SHALL be IDLE, LOAD_A, LOAD_B, MAC, OUT; all transitions on rising clk.
REQ-004 IDLE+start: dimensions latched; legal iff all four in 1..MAX_DIM and a_cols==b_rows; legal -> LOAD_A, illegal -> illegal=1 for one cycle, stay IDLE.
REQ-005 start outside IDLE SHALL be ignored; latched dimensions SHALL NOT change mid-job.
REQ-006 in_ready SHALL be 1 only in LOAD_A/LOAD_B; each handshake writes one element at row/col counters, col wraps at cols-1 and increments row.
REQ-007 LOAD_A -> LOAD_B after the a_rows*a_cols-th handshake; LOAD_B -> MAC after the b_rows*b_cols-th handshake; no bubble required between matrices.
REQ-008 MAC SHALL perform one DATA_W x DATA_W signed multiply-accumulate per cycle, acc cleared at element start, exactly a_cols cycles per element, then -> OUT.
REQ-009 Accumulation SHALL be sign-extended to ACC_W with no saturation; ACC_W default guarantees no overflow.
REQ-010 OUT SHALL hold out_valid=1 and stable out_data/out_row_end/out_last until out_ready; on handshake advance column (wrap to next row at b_cols-1) and return to MAC, or to IDLE after the final element.
REQ-011 done SHALL pulse one cycle on the cycle after the final OUT handshake; busy low that same cycle.
REQ-012 Latency per element: a_cols MAC cycles + 1 OUT cycle minimum; total compute for full-rate sink = a_rows*b_cols*(a_cols+1) cycles.
REQ-013 1x1 jobs and MAX_DIM x MAX_DIM jobs SHALL be supported with identical rules; elements outside latched dimensions SHALL never be read.
REQ-014 in_valid outside LOAD states and out_ready outside OUT SHALL have no effect.

Reset
REQ-015 rst low SHALL immediately force state IDLE and all outputs 0 (in_ready, out_valid, out_data, out_row_end, out_last, illegal, busy, done), counters and accumulator 0.
REQ-016 Matrix storage need not be cleared; reset mid-job SHALL abandon the job with no done pulse.
REQ-017 First start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-018 Package matrix_pkg SHALL hold the state enum and default DATA_W/MAX_DIM constants.
REQ-019 Sub-module matrix_mac_pe SHALL contain the multiplier and accumulator (clear, enable, operands, acc out).

Verification
REQ-020 2x3 A=[1 2 3;4 5 6] x 3x2 B=[7 8;9 10;11 12], out_ready=1 -> out_data 58,64,139,154; out_row_end on 64,154; out_last on 154; done one cycle later.
REQ-021 a_cols=3, b_rows=2 -> illegal pulse one cycle, in_ready stays 0, busy stays 0; a_rows=0 -> same.
REQ-022 4x4 A all -128, B all -128 -> every out_data = 65536, no overflow at ACC_W=18.
REQ-023 Random out_ready (50%) on REQ-020 job -> same values/order, out_data stable while out_valid&&!out_ready.
REQ-024 rst low during LOAD_B -> all outputs 0 asynchronously, no done; next 1x1 job A=[-3], B=[5] -> out_data -15 with out_row_end=out_last=1.
REQ-025 start pulsed during MAC -> ignored, results of running job unchanged.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiply-accumulate core.
// Holds the controller state encoding and the default element width / matrix size.
package matrix_pkg;

    localparam int unsigned DEFAULT_DATA_W  = 8;
    localparam int unsigned DEFAULT_MAX_DIM = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StMac,
        StOut
    } state_e;

endpackage

// File: rtl/matrix_mac_pe.sv
// Signed multiply-accumulate processing element.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear         start a new sum with this cycle's product (only when en)
//   en            accumulate op_a*op_b this cycle
//   op_a, op_b    signed DATA_W operands
//   acc           signed ACC_W running sum
module matrix_mac_pe
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(DEFAULT_MAX_DIM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] op_a,
    input  logic signed [DATA_W-1:0] op_b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;

    assign prod     = op_a * op_b;
    assign prod_ext = ACC_W'(prod);  // sign-extending size cast

    // Clear folds into the first product so no idle cycle is spent per element.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= (clear ? '0 : acc_q) + prod_ext;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matrix_mac_core.sv
// Matrix multiply core: loads A (a_rows x a_cols) then B (b_rows x b_cols) row-major over a
// valid/ready stream, computes C = A x B one element at a time and streams C out row-major.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   start, a_rows..b_cols           job request and dimensions (sampled in idle only)
//   in_valid, in_ready, in_data     element input stream
//   out_valid, out_ready, out_data  result stream, with out_row_end / out_last markers
//   illegal, done                   one-cycle pulses: job rejected / job complete
//   busy                            controller not idle
module matrix_mac_core
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned MAX_DIM = DEFAULT_MAX_DIM,
    parameter int unsigned ACC_W   = 2 * DATA_W + $clog2(MAX_DIM),
    parameter int unsigned DIM_W   = $clog2(MAX_DIM + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  a_rows,
    input  logic [DIM_W-1:0]  a_cols,
    input  logic [DIM_W-1:0]  b_rows,
    input  logic [DIM_W-1:0]  b_cols,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_row_end,
    output logic              out_last,
    output logic              illegal,
    output logic              busy,
    output logic              done
);

    localparam int unsigned DEPTH = MAX_DIM * MAX_DIM;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e             state_q, state_d;
    logic [DIM_W-1:0]   row_q, row_d, col_q, col_d, k_q, k_d;
    logic [DIM_W-1:0]   a_rows_q, a_cols_q, b_rows_q, b_cols_q;
    logic [DIM_W-1:0]   ld_rows, ld_cols;
    logic               illegal_q, illegal_d, done_q, done_d;
    logic               dims_legal, wr_a, wr_b, pe_clear, pe_en;
    logic [IDX_W-1:0]   wr_idx, a_rd_idx, b_rd_idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] a_mem [DEPTH];
    logic signed [DATA_W-1:0] b_mem [DEPTH];

    assign dims_legal = (a_rows != '0) && (a_rows <= DIM_W'(MAX_DIM)) &&
                        (a_cols != '0) && (a_cols <= DIM_W'(MAX_DIM)) &&
                        (b_rows != '0) && (b_rows <= DIM_W'(MAX_DIM)) &&
                        (b_cols != '0) && (b_cols <= DIM_W'(MAX_DIM)) &&
                        (a_cols == b_rows);

    // Storage is laid out with a fixed MAX_DIM row pitch regardless of job size.
    assign wr_idx   = IDX_W'(row_q * MAX_DIM + col_q);
    assign a_rd_idx = IDX_W'(row_q * MAX_DIM + k_q);
    assign b_rd_idx = IDX_W'(k_q * MAX_DIM + col_q);

    assign ld_rows = (state_q == StLoadA) ? a_rows_q : b_rows_q;
    assign ld_cols = (state_q == StLoadA) ? a_cols_q : b_cols_q;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        k_d       = k_q;
        illegal_d = 1'b0;
        done_d    = 1'b0;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        pe_clear  = 1'b0;
        pe_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (dims_legal) begin
                        state_d = StLoadA;
                        row_d   = '0;
                        col_d   = '0;
                        k_d     = '0;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StLoadA, StLoadB: begin
                if (in_valid) begin
                    wr_a = (state_q == StLoadA);
                    wr_b = (state_q == StLoadB);
                    if (col_q == ld_cols - DIM_W'(1)) begin
                        col_d = '0;
                        if (row_q == ld_rows - DIM_W'(1)) begin
                            row_d   = '0;
                            k_d     = '0;
                            state_d = (state_q == StLoadA) ? StLoadB : StMac;
                        end else begin
                            row_d = row_q + DIM_W'(1);
                        end
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            StMac: begin
                // row_q/col_q now address the C element being computed.
                pe_en    = 1'b1;
                pe_clear = (k_q == '0);
                if (k_q == a_cols_q - DIM_W'(1)) begin
                    k_d     = '0;
                    state_d = StOut;
                end else begin
                    k_d = k_q + DIM_W'(1);
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StMac;
                    if (col_q == b_cols_q - DIM_W'(1)) begin
                        col_d = '0;
                        if (row_q == a_rows_q - DIM_W'(1)) begin
                            row_d   = '0;
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + DIM_W'(1);
                        end
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            row_q     <= '0;
            col_q     <= '0;
            k_q       <= '0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            k_q       <= k_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rows_q <= '0;
            a_cols_q <= '0;
            b_rows_q <= '0;
            b_cols_q <= '0;
        end else if (state_q == StIdle && start) begin
            a_rows_q <= a_rows;
            a_cols_q <= a_cols;
            b_rows_q <= b_rows;
            b_cols_q <= b_cols;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_a) a_mem[wr_idx] <= in_data;
        if (wr_b) b_mem[wr_idx] <= in_data;
    end

    matrix_mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clear (pe_clear),
        .en    (pe_en),
        .op_a  (a_mem[a_rd_idx]),
        .op_b  (b_mem[b_rd_idx]),
        .acc   (acc)
    );

    assign in_ready    = (state_q == StLoadA) || (state_q == StLoadB);
    assign out_valid   = (state_q == StOut);
    assign out_data    = out_valid ? acc : '0;
    assign out_row_end = out_valid && (col_q == b_cols_q - DIM_W'(1));
    assign out_last    = out_row_end && (row_q == a_rows_q - DIM_W'(1));
    assign illegal     = illegal_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;

endmodule

// File: tb/tb_matrix_mac_core.sv
module tb_matrix_mac_core;

    localparam int DATA_W  = 8;
    localparam int MAX_DIM = 4;
    localparam int ACC_W   = 18;
    localparam int DIM_W   = 3;

    logic              clk, rst, start;
    logic [DIM_W-1:0]  a_rows, a_cols, b_rows, b_cols;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_row_end, out_last, illegal, busy, done;

    matrix_mac_core #(
        .DATA_W  (DATA_W),
        .MAX_DIM (MAX_DIM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_rows      (a_rows),
        .a_cols      (a_cols),
        .b_rows      (b_rows),
        .b_cols      (b_cols),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row_end (out_row_end),
        .out_last    (out_last),
        .illegal     (illegal),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        int data;
        bit row_end;
        bit last;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_hs_cyc = 0;
    bit   rand_ready = 0;
    int   ma [16];
    int   mb [16];
    exp_t exp_q [$];
    int   got_q [$];

    initial clk = 0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: C[r][c] = sum_k A[r][k]*B[k][c], emitted row-major.
    task automatic model_push(int ar, int ac, int bc);
        for (int r = 0; r < ar; r++) begin
            for (int c = 0; c < bc; c++) begin
                exp_t e;
                int   s = 0;
                for (int k = 0; k < ac; k++) s += ma[r*ac+k] * mb[k*bc+c];
                e.data    = s;
                e.row_end = (c == bc - 1);
                e.last    = (r == ar - 1) && (c == bc - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Output compare process.
    initial begin
        bit   hold_prev = 0;
        bit   expect_done = 0;
        int   prev_data = 0;
        bit   prev_re = 0, prev_last = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_prev   = 0;
                expect_done = 0;
            end else begin
                if (expect_done) begin
                    check("done_pulse", int'(done), 1);
                    check("busy_at_done", int'(busy), 0);
                    expect_done = 0;
                end else if (done) begin
                    check("unexpected_done", int'(done), 0);
                end
                if (done) done_cnt++;
                if (out_valid) begin
                    if (hold_prev) begin
                        check("hold_data", int'($signed(out_data)), prev_data);
                        check("hold_row_end", int'(out_row_end), int'(prev_re));
                        check("hold_last", int'(out_last), int'(prev_last));
                    end
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_out", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_data", int'($signed(out_data)), e.data);
                            check("out_row_end", int'(out_row_end), int'(e.row_end));
                            check("out_last", int'(out_last), int'(e.last));
                        end
                        got_q.push_back(int'($signed(out_data)));
                        if (out_last) begin
                            last_hs_cyc = cyc;
                            expect_done = 1;
                        end
                        hold_prev = 0;
                    end else begin
                        hold_prev = 1;
                        prev_data = int'($signed(out_data));
                        prev_re   = out_row_end;
                        prev_last = out_last;
                    end
                end else begin
                    hold_prev = 0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    task automatic send(int v, output int hs_cyc);
        in_data  = v[DATA_W-1:0];
        in_valid = 1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic do_start(int ar, int ac, int br, int bc);
        a_rows = DIM_W'(ar);
        a_cols = DIM_W'(ac);
        b_rows = DIM_W'(br);
        b_cols = DIM_W'(bc);
        start  = 1;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic load_and_wait(int ar, int ac, int br, int bc, bit glitch, bit chk_lat,
                                 int lat_exp);
        int hs = 0;
        int d0 = done_cnt;
        for (int i = 0; i < ar * ac; i++) send(ma[i], hs);
        for (int i = 0; i < br * bc; i++) send(mb[i], hs);
        if (glitch) begin
            do_start(1, 1, 1, 1);
            check("busy_after_glitch", int'(busy), 1);
            check("in_ready_after_glitch", int'(in_ready), 0);
        end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) break;
        end
        check("done_seen", done_cnt - d0, 1);
        if (chk_lat) check("latency", last_hs_cyc - hs, lat_exp);
        check("exp_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_out_row_end"}, int'(out_row_end), 0);
        check({tag, "_out_last"}, int'(out_last), 0);
        check({tag, "_illegal"}, int'(illegal), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    task automatic set_2x3_3x2();
        for (int i = 0; i < 6; i++) begin
            ma[i] = i + 1;
            mb[i] = i + 7;
        end
    endtask

    task automatic check_2x3_results(string tag);
        int lit [4] = '{58, 64, 139, 154};
        check({tag, "_count"}, got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check({tag, "_val"}, got_q[i], lit[i]);
    endtask

    initial begin
        int hs = 0;
        int d0;
        rst = 0; start = 0; in_valid = 0; in_data = '0; out_ready = 1;
        a_rows = '0; a_cols = '0; b_rows = '0; b_cols = '0;
        #3;
        check_outputs_zero("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;

        // 2x3 * 3x2, full-rate sink.
        set_2x3_3x2();
        got_q.delete();
        model_push(2, 3, 2);
        do_start(2, 3, 3, 2);
        check("start_in_ready", int'(in_ready), 1);
        check("start_busy", int'(busy), 1);
        load_and_wait(2, 3, 3, 2, 0, 1, 16);
        check_2x3_results("basic");

        // Rejected jobs.
        do_start(2, 3, 2, 2);
        check("illegal_pulse_a", int'(illegal), 1);
        check("illegal_in_ready_a", int'(in_ready), 0);
        check("illegal_busy_a", int'(busy), 0);
        @(posedge clk);
        #1;
        check("illegal_drop_a", int'(illegal), 0);
        check("illegal_in_ready_a2", int'(in_ready), 0);
        do_start(0, 2, 2, 2);
        check("illegal_pulse_b", int'(illegal), 1);
        check("illegal_busy_b", int'(busy), 0);
        @(posedge clk);
        #1;
        check("illegal_drop_b", int'(illegal), 0);

        // 4x4 extreme values: every element 4 * 16384.
        for (int i = 0; i < 16; i++) begin
            ma[i] = -128;
            mb[i] = -128;
        end
        got_q.delete();
        model_push(4, 4, 4);
        do_start(4, 4, 4, 4);
        load_and_wait(4, 4, 4, 4, 0, 1, 80);
        check("max_count", got_q.size(), 16);
        for (int i = 0; i < got_q.size(); i++) check("max_val", got_q[i], 65536);

        // Random back-pressure.
        set_2x3_3x2();
        got_q.delete();
        model_push(2, 3, 2);
        rand_ready = 1;
        do_start(2, 3, 3, 2);
        load_and_wait(2, 3, 3, 2, 0, 0, 0);
        rand_ready = 0;
        @(posedge clk);
        #1;
        check_2x3_results("backpressure");

        // start pulsed during MAC is ignored.
        got_q.delete();
        model_push(2, 3, 2);
        do_start(2, 3, 3, 2);
        load_and_wait(2, 3, 3, 2, 1, 1, 16);
        check_2x3_results("glitch");

        // Reset during LOAD_B, then a 1x1 job started on the first edge after release.
        d0 = done_cnt;
        do_start(2, 3, 3, 2);
        for (int i = 0; i < 6; i++) send(ma[i], hs);
        for (int i = 0; i < 2; i++) send(mb[i], hs);
        check("loadb_in_ready", int'(in_ready), 1);
        #2;
        rst = 0;
        #1;
        check_outputs_zero("midjob_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        check("no_done_after_reset", done_cnt - d0, 0);
        @(negedge clk);
        rst = 1;
        ma[0] = -3;
        mb[0] = 5;
        got_q.delete();
        model_push(1, 1, 1);
        do_start(1, 1, 1, 1);
        check("first_start_accepted", int'(in_ready), 1);
        load_and_wait(1, 1, 1, 1, 0, 1, 2);
        check("one_count", got_q.size(), 1);
        if (got_q.size() > 0) check("one_val", got_q[0], -15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
